// File: rtl/stack_unit.sv
// rtl/stack_unit.sv - LIFO stack with push/pop/top-of-stack/replace and sticky error flags
module stack_unit #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       tos,
    input  logic                       clr_err,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    sp;
    logic [AW-1:0]    top_addr;
    logic [AW-1:0]    wr_addr;
    logic             wr_en;
    logic             do_replace;
    logic             do_pop;
    logic             do_push;
    logic             do_tos;

    assign count = sp;
    assign full  = (sp == DEPTH_C);
    assign empty = (sp == '0);

    always_comb begin
        do_replace = push & pop;
        do_pop     = pop & ~push;
        do_push    = push & ~pop;
        do_tos     = tos & ~push & ~pop;
        top_addr   = AW'(sp - CW'(1));
        // sp < DEPTH whenever a push is accepted, so its low bits address the next free slot
        wr_en      = (do_push & ~full) | (do_replace & ~empty);
        wr_addr    = do_replace ? top_addr : sp[AW-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp        <= '0;
            dout      <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (clr_err) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end
            // error sets come after the clear so a same-cycle event wins
            if (do_replace) begin
                if (empty) underflow <= 1'b1;
                else       dout      <= mem[top_addr];
            end else if (do_pop) begin
                if (empty) begin
                    underflow <= 1'b1;
                end else begin
                    dout <= mem[top_addr];
                    sp   <= sp - CW'(1);
                end
            end else if (do_push) begin
                if (full) overflow <= 1'b1;
                else      sp       <= sp + CW'(1);
            end else if (do_tos) begin
                if (empty) underflow <= 1'b1;
                else       dout      <= mem[top_addr];
            end
        end
    end

    // Array is not reset; writes are suppressed while reset is held
    always_ff @(posedge clk) begin
        if (rst && wr_en) begin
            mem[wr_addr] <= din;
        end
    end

endmodule
